adc_sample_packetizer: RTL

Upstream feeder for fifo_interface's transmit side, replacing the counter pattern source used in bring-up. It buffers ADC samples in a small synchronous FIFO and frames each one into a 5-byte packet. Packets are emitted one byte per single-cycle strobe, with strobes paced by a programmable gap so the USB FIFO is never over-driven. It drives tx_data_rdy_i / tx_data_i of fifo_interface directly.

---
 rtl/adc_sample_packetizer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adc_sample_packetizer.sv
// ADC sample packetizer: buffers samples in a small FIFO and emits each one as a
// 5-byte packet (HEADER, SEQ, S[15:8], S[7:0], XOR checksum), one paced strobe per byte.
module adc_sample_packetizer #(
    parameter int         SAMPLE_W   = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         BYTE_GAP   = 878,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        sample_valid_i,
    input  logic [SAMPLE_W-1:0]         sample_i,
    input  logic                        clear_overflow_i,
    output logic                        tx_data_rdy_o,
    output logic [7:0]                  tx_data_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BYTE_GAP);
    localparam logic [TW-1:0] GAP_LOAD = TW'(BYTE_GAP - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1
    } state_t;

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic                r_overflow;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_sample;
    logic [7:0]          r_pkt_seq;
    logic [7:0]          r_seq;
    logic [2:0]          r_idx;
    logic [TW-1:0]       r_timer;
    logic [7:0]          r_tx_data;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_strobe;
    logic [7:0]          w_byte;
    logic [7:0]          w_chk;

    // Reset asserts immediately, releases two clock edges after reset_ni rises.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_push  = sample_valid_i && (!w_full || w_pop);
    assign w_drop  = sample_valid_i && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= sample_i;
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear wins.
            if (w_drop)                r_overflow <= 1'b1;
            else if (clear_overflow_i) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_empty ? S_IDLE : S_SEND;
            S_SEND:  w_state_nxt = (w_strobe && r_idx == 3'd4) ? S_IDLE : S_SEND;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop    = 1'b0;
        w_strobe = 1'b0;
        busy_o   = 1'b0;
        case (r_state)
            S_IDLE: w_pop = !w_empty;
            S_SEND: begin
                busy_o   = 1'b1;
                w_strobe = (r_timer == '0);
            end
            default: ;
        endcase
    end

    // The gap timer keeps running through IDLE, so the pop cycle overlaps the gap.
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sample  <= '0;
            r_pkt_seq <= '0;
            r_seq     <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_pop) begin
                r_sample  <= 16'(r_mem[r_rd_ptr]);
                r_pkt_seq <= r_seq;
                r_seq     <= r_seq + 8'd1;
                r_idx     <= '0;
            end
            if (w_strobe) begin
                r_idx     <= r_idx + 3'd1;
                r_timer   <= GAP_LOAD;
                r_tx_data <= w_byte;
            end else if (r_timer != '0) begin
                r_timer   <= r_timer - TW'(1);
            end
        end
    end

    always_comb begin
        w_chk = HEADER ^ r_pkt_seq ^ r_sample[15:8] ^ r_sample[7:0];
        case (r_idx)
            3'd0:    w_byte = HEADER;
            3'd1:    w_byte = r_pkt_seq;
            3'd2:    w_byte = r_sample[15:8];
            3'd3:    w_byte = r_sample[7:0];
            default: w_byte = w_chk;
        endcase
    end

    assign tx_data_rdy_o = w_strobe;
    assign tx_data_o     = w_strobe ? w_byte : r_tx_data;
    assign overflow_o    = r_overflow;
    assign fifo_level_o  = r_level;

endmodule
